// File: rtl/my_pkg.sv
// Shared decode types: operation enum, format enum, opcodes.
// M_EXT_EN adds the RV32M operations to i_type.
package my_pkg;

    typedef enum logic [5:0] {
        NOP, ADD, SUB, SLL, SLT, SLTU,
        XOR, SRL, SRA, OR, AND,
        LUI, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ECALL, EBREAK, SRET, MRET, WFI,
        INVALID
`ifdef M_EXT_EN
        , MUL, MULH, MULHSU, MULHU,
        DIV, DIVU, REM, REMU
`endif
    } i_type;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S,
        FMT_B, FMT_U, FMT_J
    } fmts;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] ENC_NOP    = 32'h0000_0013;
    localparam logic [31:0] ENC_ECALL  = 32'h0000_0073;
    localparam logic [31:0] ENC_EBREAK = 32'h0010_0073;
    localparam logic [31:0] ENC_SRET   = 32'h1020_0073;
    localparam logic [31:0] ENC_MRET   = 32'h3020_0073;
    localparam logic [31:0] ENC_WFI    = 32'h1050_0073;

    function automatic fmts fmt_of(input logic [6:0] opc);
        unique case (opc)
            OPC_LUI, OPC_AUIPC: fmt_of = FMT_U;
            OPC_JAL:            fmt_of = FMT_J;
            OPC_BRANCH:         fmt_of = FMT_B;
            OPC_STORE:          fmt_of = FMT_S;
            OPC_OP:             fmt_of = FMT_R;
            default:            fmt_of = FMT_I;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_lock_queue.sv
// Shift register of in-flight rd targets and store flags.
// Ports: shift_en/target/is_store in; rs hits, mem_pending, oldest out.
module lock_queue
    import my_pkg::*;
#(
    parameter int LOCK_DEPTH = 2,
    parameter int RF_ADDR_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 shift_en,
    input  logic [RF_ADDR_W-1:0] target,
    input  logic                 is_store,
    input  logic [RF_ADDR_W-1:0] rs1,
    input  logic [RF_ADDR_W-1:0] rs2,
    output logic                 rs1_hit,
    output logic                 rs2_hit,
    output logic                 mem_pending,
    output logic [RF_ADDR_W-1:0] oldest
);

    logic [RF_ADDR_W-1:0] lock_reg [LOCK_DEPTH];
    logic [LOCK_DEPTH-1:0] lock_mem;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < LOCK_DEPTH; k++)
                lock_reg[k] <= '0;
            lock_mem <= '0;
        end else if (shift_en) begin
            lock_reg[0] <= target;
            lock_mem[0] <= is_store;
            for (int k = 1; k < LOCK_DEPTH; k++) begin
                lock_reg[k] <= lock_reg[k-1];
                lock_mem[k] <= lock_mem[k-1];
            end
        end
    end

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int k = 0; k < LOCK_DEPTH; k++) begin
            if (lock_reg[k] == rs1) rs1_hit = 1'b1;
            if (lock_reg[k] == rs2) rs2_hit = 1'b1;
        end
    end

    assign mem_pending = |lock_mem;
    assign oldest      = lock_reg[LOCK_DEPTH-1];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: classify, immediate, operands, hazard bubbles.
// Ports: fetch/regfile in; registered operands, hazard, counter out. M_EXT_EN adds RV32M.
module decode_stage
    import my_pkg::*;
#(
    parameter int LOCK_DEPTH = 2,
    parameter int RF_ADDR_W  = 5,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [31:0]          instruction_in,
    input  logic [31:0]          NPC_in,
    input  logic [3:0]           tag_in,
    input  logic [31:0]          dataA,
    input  logic [31:0]          dataB,
    output logic [RF_ADDR_W-1:0] regA_add,
    output logic [RF_ADDR_W-1:0] regB_add,
    output logic [RF_ADDR_W-1:0] wrAddr,
    output logic [31:0]          opA,
    output logic [31:0]          opB,
    output logic [31:0]          opC,
    output logic [31:0]          NPC,
    output logic [31:0]          instruction_out,
    output i_type                i_out,
    output logic [3:0]           tag,
    output logic                 hazard,
    output logic                 exception,
    output logic [CNT_W-1:0]     hazard_count
);

    logic [31:0] last_inst;
    logic        last_hazard;
    logic [31:0] inst;
    i_type       op;
    fmts         fmt;
    logic [31:0] imm;
    logic [31:0] op_a, op_b, op_c;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [RF_ADDR_W-1:0] rs1, rs2, rd, target;
    logic rs1_used, rs2_used, is_load, is_st;
    logic rs1_hit, rs2_hit, mem_pending;

    // A bubbled instruction is held and decoded again next cycle.
    assign inst = last_hazard ? last_inst : instruction_in;
    assign opc  = inst[6:0];
    assign f3   = inst[14:12];
    assign f7   = inst[31:25];
    assign rs1  = inst[15 +: RF_ADDR_W];
    assign rs2  = inst[20 +: RF_ADDR_W];
    assign rd   = inst[7 +: RF_ADDR_W];
    assign fmt  = fmt_of(opc);

    assign regA_add = rs1;
    assign regB_add = rs2;

    always_comb begin
        op = INVALID;
        case (opc)
            OPC_LUI:   op = LUI;
            OPC_AUIPC: op = ADD;
            OPC_JAL:   op = JAL;
            OPC_JALR:  if (f3 == 3'd0) op = JALR;
            OPC_BRANCH:
                case (f3)
                    3'd0:    op = BEQ;
                    3'd1:    op = BNE;
                    3'd4:    op = BLT;
                    3'd5:    op = BGE;
                    3'd6:    op = BLTU;
                    3'd7:    op = BGEU;
                    default: op = INVALID;
                endcase
            OPC_LOAD:
                case (f3)
                    3'd0:    op = LB;
                    3'd1:    op = LH;
                    3'd2:    op = LW;
                    3'd4:    op = LBU;
                    3'd5:    op = LHU;
                    default: op = INVALID;
                endcase
            OPC_STORE:
                case (f3)
                    3'd0:    op = SB;
                    3'd1:    op = SH;
                    3'd2:    op = SW;
                    default: op = INVALID;
                endcase
            OPC_OPIMM:
                if (inst == ENC_NOP) op = NOP;
                else
                    case (f3)
                        3'd0: op = ADD;
                        3'd2: op = SLT;
                        3'd3: op = SLTU;
                        3'd4: op = XOR;
                        3'd6: op = OR;
                        3'd7: op = AND;
                        3'd1: if (f7 == 7'h00) op = SLL;
                        default:
                            if (f7 == 7'h00)      op = SRL;
                            else if (f7 == 7'h20) op = SRA;
                    endcase
            OPC_OP:
                case ({f7, f3})
                    {7'h00, 3'd0}: op = ADD;
                    {7'h20, 3'd0}: op = SUB;
                    {7'h00, 3'd1}: op = SLL;
                    {7'h00, 3'd2}: op = SLT;
                    {7'h00, 3'd3}: op = SLTU;
                    {7'h00, 3'd4}: op = XOR;
                    {7'h00, 3'd5}: op = SRL;
                    {7'h20, 3'd5}: op = SRA;
                    {7'h00, 3'd6}: op = OR;
                    {7'h00, 3'd7}: op = AND;
`ifdef M_EXT_EN
                    {7'h01, 3'd0}: op = MUL;
                    {7'h01, 3'd1}: op = MULH;
                    {7'h01, 3'd2}: op = MULHSU;
                    {7'h01, 3'd3}: op = MULHU;
                    {7'h01, 3'd4}: op = DIV;
                    {7'h01, 3'd5}: op = DIVU;
                    {7'h01, 3'd6}: op = REM;
                    {7'h01, 3'd7}: op = REMU;
`endif
                    default:       op = INVALID;
                endcase
            OPC_FENCE: if (f3 == 3'd0) op = NOP;
            OPC_SYSTEM:
                case (inst)
                    ENC_ECALL:  op = ECALL;
                    ENC_EBREAK: op = EBREAK;
                    ENC_SRET:   op = SRET;
                    ENC_MRET:   op = MRET;
                    ENC_WFI:    op = WFI;
                    default:    op = INVALID;
                endcase
            default: op = INVALID;
        endcase
    end

    always_comb begin
        unique case (fmt)
            FMT_I: imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm = {{20{inst[31]}}, inst[31:25],
                          inst[11:7]};
            FMT_B: imm = {{19{inst[31]}}, inst[31], inst[7],
                          inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm = {inst[31:12], 12'b0};
            FMT_J: imm = {{11{inst[31]}}, inst[31],
                          inst[19:12], inst[20],
                          inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign op_a = (fmt == FMT_U || fmt == FMT_J) ? NPC_in : dataA;
    assign op_b = (fmt == FMT_R || fmt == FMT_B) ? dataB : imm;
    assign op_c = (fmt == FMT_S) ? dataB : imm;

    assign rs1_used = !(fmt == FMT_U || fmt == FMT_J);
    assign rs2_used = fmt == FMT_R || fmt == FMT_S || fmt == FMT_B;
    assign is_load  = op inside {LB, LH, LW, LBU, LHU};

    assign hazard = (rs1_used && rs1 != '0 && rs1_hit)
                 || (rs2_used && rs2 != '0 && rs2_hit)
                 || (is_load && mem_pending);

    always_comb begin
        target = '0;
        is_st  = 1'b0;
        if (!hazard && !flush) begin
            if (fmt != FMT_S && fmt != FMT_B && op != INVALID)
                target = rd;
            is_st = op inside {SB, SH, SW};
        end
    end

    lock_queue #(
        .LOCK_DEPTH(LOCK_DEPTH),
        .RF_ADDR_W (RF_ADDR_W)
    ) u_lock_queue (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (!stall),
        .target     (target),
        .is_store   (is_st),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_hit    (rs1_hit),
        .rs2_hit    (rs2_hit),
        .mem_pending(mem_pending),
        .oldest     (wrAddr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            opA             <= '0;
            opB             <= '0;
            opC             <= '0;
            NPC             <= '0;
            instruction_out <= '0;
            tag             <= '0;
            i_out           <= NOP;
            exception       <= 1'b0;
            last_inst       <= '0;
            last_hazard     <= 1'b0;
            hazard_count    <= '0;
        end else if (!stall) begin
            last_inst <= inst;
            if (flush || hazard) begin
                opA             <= '0;
                opB             <= '0;
                opC             <= '0;
                NPC             <= '0;
                instruction_out <= '0;
                tag             <= '0;
                i_out           <= NOP;
                exception       <= 1'b0;
                last_hazard     <= !flush;
                if (!flush && hazard_count != '1)
                    hazard_count <= hazard_count + 1'b1;
            end else begin
                opA             <= op_a;
                opB             <= op_b;
                opC             <= op_c;
                NPC             <= NPC_in;
                instruction_out <= inst;
                tag             <= tag_in;
                i_out           <= op;
                exception       <= (op == INVALID);
                last_hazard     <= 1'b0;
            end
        end
    end

endmodule
